// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard decoder bus: raw pins in, steering levels and event pulses out.
interface ps2_key_decoder_if;
    logic ps2Clk;
    logic ps2Data;
    logic left;
    logic right;
    logic invincibleToggle;
    logic frameError;

    // Keyboard/driver side.
    modport master (
        output ps2Clk,
        output ps2Data,
        input  left,
        input  right,
        input  invincibleToggle,
        input  frameError
    );

    // Decoder side.
    modport slave (
        input  ps2Clk,
        input  ps2Data,
        output left,
        output right,
        output invincibleToggle,
        output frameError
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: pin synchronisers, 11-bit frame receiver with odd
// parity, stop check and inter-edge watchdog, and an E0/F0 aware scan-code
// decoder driving held left/right levels and an invincibility toggle pulse.
module ps2_key_decoder #(
    parameter logic [7:0]  LEFT_CODE      = 8'h6B,
    parameter logic [7:0]  RIGHT_CODE     = 8'h74,
    parameter logic [7:0]  INV_CODE       = 8'h43,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic             clk,
    input logic             resetN,
    ps2_key_decoder_if.slave bus
);

    localparam logic [7:0]  ExtCode = 8'hE0;
    localparam logic [7:0]  BrkCode = 8'hF0;
    localparam int unsigned WdWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic [1:0] clkSync_q;
    logic [1:0] dataSync_q;
    logic       clkPrev_q;
    logic       fallEdge;
    logic       rxData;

    // Two-flop synchronisers; reset to 1 so an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], bus.ps2Clk};
            dataSync_q <= {dataSync_q[0], bus.ps2Data};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    assign fallEdge = clkPrev_q & ~clkSync_q[1];
    assign rxData   = dataSync_q[1];

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    rx_state_e          state_q, state_d;
    logic [2:0]         bitCnt_q, bitCnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic [WdWidth-1:0] wdCnt_q, wdCnt_d;
    logic               byteValid_q, byteValid_d;
    logic               frameError_q, frameError_d;
    logic               wdExpired;

    // Receiver state, shift register, watchdog and the registered event pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StIdle;
            bitCnt_q     <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            wdCnt_q      <= '0;
            byteValid_q  <= 1'b0;
            frameError_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            wdCnt_q      <= wdCnt_d;
            byteValid_q  <= byteValid_d;
            frameError_q <= frameError_d;
        end
    end

    assign wdExpired = (state_q != StIdle) && (wdCnt_q == WdLast);

    // Next-state logic: frame bits are only sampled on synced falling edges.
    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byteValid_d  = 1'b0;
        frameError_d = 1'b0;

        // Watchdog only runs inside a frame and restarts on every edge.
        if (state_q == StIdle || fallEdge) begin
            wdCnt_d = '0;
        end else begin
            wdCnt_d = wdCnt_q + 1'b1;
        end

        if (wdExpired) begin
            // Stalled keyboard clock: drop the partial byte.
            state_d      = StIdle;
            wdCnt_d      = '0;
            frameError_d = 1'b1;
        end else if (fallEdge) begin
            unique case (state_q)
                StIdle: begin
                    // A high level here is just line noise, not a start bit.
                    if (!rxData) begin
                        state_d  = StData;
                        bitCnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d  = {rxData, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = rxData;
                    state_d  = StStop;
                end
                StStop: begin
                    if ((^{shift_q, parity_q}) && rxData) begin
                        byteValid_d = 1'b1;
                    end else begin
                        frameError_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------
    logic ext_q, ext_d;
    logic brk_q, brk_d;
    logic left_q, left_d;
    logic right_q, right_d;
    logic inv_q, inv_d;

    // Prefix flags and the decoded output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            left_q  <= left_d;
            right_q <= right_d;
            inv_q   <= inv_d;
        end
    end

    // shift_q still holds the accepted byte in the cycle byteValid_q is high.
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        left_d  = left_q;
        right_d = right_q;
        inv_d   = 1'b0;

        if (frameError_q) begin
            // A corrupt frame may have been a prefix; forget any pending one.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byteValid_q) begin
            if (shift_q == ExtCode) begin
                ext_d = 1'b1;
            end else if (shift_q == BrkCode) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q && shift_q == LEFT_CODE) begin
                    left_d = !brk_q;
                end
                if (ext_q && shift_q == RIGHT_CODE) begin
                    right_d = !brk_q;
                end
                if (!ext_q && !brk_q && shift_q == INV_CODE) begin
                    inv_d = 1'b1;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign bus.left             = left_q;
    assign bus.right            = right_q;
    assign bus.invincibleToggle = inv_q;
    assign bus.frameError       = frameError_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: frame-level behavioural model plus a per-cycle
// compare process, with hand-computed literal checkpoints.
module tb_ps2_key_decoder;

    localparam int unsigned TIMEOUT = 1000;
    localparam int          HALF    = 20;

    logic clk = 1'b0;
    logic resetN;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .LEFT_CODE     (8'h6B),
        .RIGHT_CODE    (8'h74),
        .INV_CODE      (8'h43),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Model state
    bit mExt = 0, mBrk = 0, mLeft = 0, mRight = 0;
    int expInv = 0, expErr = 0;

    // Observed pulse counts
    int invCount = 0, errCount = 0;
    bit prevInv = 0, prevErr = 0;
    bit busy = 1, running = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Effect of one received frame on the expected outputs.
    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            mExt = 0;
            mBrk = 0;
            expErr++;
        end else if (b == 8'hE0) begin
            mExt = 1;
        end else if (b == 8'hF0) begin
            mBrk = 1;
        end else begin
            if (mExt && b == 8'h6B) mLeft = !mBrk;
            if (mExt && b == 8'h74) mRight = !mBrk;
            if (!mExt && !mBrk && b == 8'h43) expInv++;
            mExt = 0;
            mBrk = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flipPar);
        logic [10:0] bits;
        logic        par;
        par  = ~(^b) ^ flipPar;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.ps2Data = bits[i];
            wait_clk(HALF);
            if (i == 10) busy = 1;
            bus.ps2Clk = 1'b0;
            if (i == 10) begin
                // Outputs must settle within 5 clk of the raw stop edge.
                wait_clk(5);
                model_frame(b, flipPar);
                busy = 0;
                wait_clk(HALF - 5);
            end else begin
                wait_clk(HALF);
            end
            bus.ps2Clk = 1'b1;
        end
        bus.ps2Data = 1'b1;
        wait_clk(3 * HALF);
    endtask

    // Start bit plus n data bits, then the keyboard clock stalls high.
    task automatic send_partial(input logic [7:0] b, input int n);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= n; i++) begin
            bus.ps2Data = bits[i];
            wait_clk(HALF);
            bus.ps2Clk = 1'b0;
            wait_clk(HALF);
            bus.ps2Clk = 1'b1;
        end
        bus.ps2Data = 1'b1;
    endtask

    // Compare process: levels against the model, pulse counting and widths.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (running) begin
                if (!busy) begin
                    check("left_level", int'(bus.left), int'(mLeft));
                    check("right_level", int'(bus.right), int'(mRight));
                end
                check("inv_pulse_width", int'(bus.invincibleToggle && prevInv), 0);
                check("err_pulse_width", int'(bus.frameError && prevErr), 0);
                if (bus.invincibleToggle) invCount++;
                if (bus.frameError) errCount++;
                prevInv = bus.invincibleToggle;
                prevErr = bus.frameError;
            end
        end
    end

    initial begin
        bus.ps2Clk  = 1'b1;
        bus.ps2Data = 1'b1;
        resetN      = 1'b0;
        wait_clk(3);
        check("reset_left", int'(bus.left), 0);
        check("reset_right", int'(bus.right), 0);
        check("reset_inv", int'(bus.invincibleToggle), 0);
        check("reset_err", int'(bus.frameError), 0);
        resetN = 1'b1;
        wait_clk(3);
        busy    = 0;
        running = 1;

        // Left arrow make then break.
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        check("e0_6b_left", int'(bus.left), 1);
        check("e0_6b_right", int'(bus.right), 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h6B, 0);
        check("e0_f0_6b_left", int'(bus.left), 0);
        check("no_err_yet", errCount, 0);

        // Both arrows held, then release right only.
        send_frame(8'hE0, 0);
        send_frame(8'h74, 0);
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        check("both_right", int'(bus.right), 1);
        check("both_left", int'(bus.left), 1);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h74, 0);
        check("rel_right_right", int'(bus.right), 0);
        check("rel_right_left", int'(bus.left), 1);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h6B, 0);

        // Keypad 4 (non-extended 6B) is ignored and leaves no prefix behind.
        send_frame(8'h6B, 0);
        check("keypad4_left", int'(bus.left), 0);
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        check("after_keypad_left", int'(bus.left), 1);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h6B, 0);

        // Invincibility: make pulses, break does not, repeat pulses again.
        send_frame(8'h43, 0);
        check("inv_first", invCount, 1);
        send_frame(8'hF0, 0);
        send_frame(8'h43, 0);
        check("inv_break", invCount, 1);
        send_frame(8'h43, 0);
        check("inv_second", invCount, 2);
        check("inv_model", invCount, expInv);

        // Parity error after E0 drops the prefix.
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 1);
        check("parity_err", errCount, 1);
        check("parity_left", int'(bus.left), 0);
        send_frame(8'h6B, 0);
        check("bare_6b_left", int'(bus.left), 0);

        // Watchdog: stall mid-frame.
        send_partial(8'h6B, 5);
        wait_clk(TIMEOUT + 50);
        model_frame(8'h00, 1);
        check("timeout_err", errCount, 2);
        check("err_model", errCount, expErr);
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        check("after_timeout_left", int'(bus.left), 1);

        // Reset in the middle of a frame.
        send_partial(8'h74, 3);
        busy   = 1;
        resetN = 1'b0;
        mLeft  = 0;
        mRight = 0;
        mExt   = 0;
        mBrk   = 0;
        wait_clk(3);
        check("midrst_left", int'(bus.left), 0);
        check("midrst_right", int'(bus.right), 0);
        check("midrst_inv", int'(bus.invincibleToggle), 0);
        check("midrst_err", int'(bus.frameError), 0);
        resetN = 1'b1;
        wait_clk(5);
        busy = 0;
        send_frame(8'hE0, 0);
        send_frame(8'h74, 0);
        check("after_rst_right", int'(bus.right), 1);
        check("final_inv_model", invCount, expInv);
        check("final_err_model", errCount, expErr);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
